apb_m_if: RTL and testbench

APB master bridge that drives the APB slave interface of the memory-mapped register/RAM block. Accepts one read or write command at a time on a valid/ready command port and runs the APB SETUP/ACCESS sequence. Waits for `pready` with a bounded timeout, then returns read data and status on a valid/ready response port. It is the stage directly upstream of the APB slave and owns `psel`, `penable`, `pwrite`, `paddr` and `pwdata`.

---
 rtl/apb_m_if.sv | 167 ++++++++++++++++
 tb/tb_apb_m_if.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_m_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_m_if
//  Description : APB master bridge. Takes one read/write command at a time on
//                a valid/ready port, runs the APB SETUP/ACCESS sequence with a
//                bounded wait for pready, and returns read data and a timeout
//                flag on a valid/ready response port.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_m_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    // APB master side
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    // Wait counter only ever reaches TIMEOUT-1, so TIMEOUT+1 values is ample.
    localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_cmd_ready;
    logic                    w_accept;
    logic                    w_done_ok;
    logic                    w_done_timeout;
    logic [c_cnt_w-1:0]      r_wait_cnt;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic                    r_rsp_write;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_timeout;

    // Commands are only offered in IDLE and never while reset is asserted.
    assign w_cmd_ready = (r_state == ST_IDLE) & ~preset;

    // State register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the one-cycle events that steer the datapath.
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_done_ok      = 1'b0;
        w_done_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && w_cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    w_done_ok    = 1'b1;
                    w_state_next = ST_RESP;
                end else if (r_wait_cnt == c_cnt_last) begin
                    w_done_timeout = 1'b1;
                    w_state_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the accepted command; it stays on the APB bus until the next one.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
        end
    end

    // Count unanswered ACCESS cycles; ACCESS is left before it can pass TIMEOUT-1.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !pready && (r_wait_cnt != c_cnt_last)) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_one;
        end
    end

    // Load the response when ACCESS ends; it is held untouched through RESP.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
        end else if (w_done_ok) begin
            r_rsp_write   <= r_pwrite;
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_timeout <= 1'b0;
        end else if (w_done_timeout) begin
            r_rsp_write   <= r_pwrite;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
        end
    end

    // APB strobes and response valid come straight from the state register.
    assign psel        = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign penable     = (r_state == ST_ACCESS);
    assign rsp_valid   = (r_state == ST_RESP);
    assign cmd_ready   = w_cmd_ready;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_m_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_m_if
//  Description : Directed self-checking bench for apb_m_if with a
//                transaction-level reference model and a simple APB slave.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_m_if;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int TB_TIMEOUT = 4;

    logic          pclk      = 1'b0;
    logic          preset    = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata    = '0;
    logic          pready    = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // slave behaviour knobs
    int slv_waits = 0;
    bit slv_never = 1'b0;
    int s_cnt     = 0;

    apb_m_if #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // issue one command from IDLE; returns in the cycle after acceptance
    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk("cmd_ready_before_accept", 64'(cmd_ready), 64'(1));
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Simple APB slave: answers after slv_waits unready ACCESS cycles.
    always @(negedge pclk) begin
        if (psel && penable) begin
            pready = !slv_never && (s_cnt >= slv_waits);
            s_cnt++;
        end else begin
            pready = 1'b0;
            s_cnt  = 0;
        end
    end

    // ---------------- reference model (transaction level) ----------------
    // m_cyc counts cycles since acceptance (1 = setup cycle); ACCESS cycle k
    // is cycle k+1. A response is produced on pready or after TIMEOUT
    // unanswered ACCESS cycles, and is held until rsp_ready.
    bit          m_busy  = 1'b0;
    bit          m_resp  = 1'b0;
    int          m_cyc   = 0;
    logic        m_write = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic        m_to    = 1'b0;

    always @(posedge pclk or posedge preset) begin
        if (preset) begin
            m_busy = 1'b0; m_resp = 1'b0; m_cyc = 0;
            m_write = 1'b0; m_addr = '0; m_wdata = '0;
            m_rdata = '0; m_to = 1'b0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy  = 1'b1;
                m_cyc   = 1;
                m_write = cmd_write;
                m_addr  = cmd_addr;
                m_wdata = cmd_wdata;
            end
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_busy = 1'b0;
                m_resp = 1'b0;
            end
        end else if (m_cyc == 1) begin
            m_cyc = 2;
        end else if (pready) begin
            m_resp  = 1'b1;
            m_rdata = m_write ? '0 : prdata;
            m_to    = 1'b0;
        end else if ((m_cyc - 1) == TB_TIMEOUT) begin
            m_resp  = 1'b1;
            m_rdata = '0;
            m_to    = 1'b1;
        end else begin
            m_cyc++;
        end
    end

    // Compare DUT against the model every cycle, mid-cycle.
    always @(negedge pclk) begin
        logic [3:0] exp_ctrl;
        exp_ctrl = {(!preset && !m_busy), (m_busy && !m_resp),
                    (m_busy && !m_resp && m_cyc >= 2), m_resp};
        chk("model_ctrl", 64'({cmd_ready, psel, penable, rsp_valid}), 64'(exp_ctrl));
        chk("model_bus", 64'({pwrite, paddr, pwdata}) , 64'({m_write, m_addr, m_wdata}));
        if (m_resp) begin
            chk("model_rsp", 64'({rsp_write, rsp_rdata, rsp_timeout}), 64'({m_write, m_rdata, m_to}));
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int n;
        int acc;
        int hits;

        // 1. reset values
        tick(); tick(); tick();
        chk("reset_ctrl", 64'({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_write, rsp_timeout}), 64'(0));
        chk("reset_bus", 64'({paddr, pwdata}), 64'(0));
        chk("reset_rdata", 64'(rsp_rdata), 64'(0));
        preset = 1'b0;
        tick();
        chk("reset_release_cmd_ready", 64'(cmd_ready), 64'(1));

        // 2. zero-wait write
        rsp_ready = 1'b1;
        slv_waits = 0;
        slv_never = 1'b0;
        do_cmd(1'b1, 32'h10, 32'hDEADBEEF);
        chk("wr_c1_psel_pen", 64'({psel, penable}), 64'(2'b10));
        chk("wr_c1_bus", 64'({pwrite, paddr, pwdata}), 64'({1'b1, 32'h10, 32'hDEADBEEF}));
        tick();
        chk("wr_c2_psel_pen", 64'({psel, penable}), 64'(2'b11));
        chk("wr_c2_bus", 64'({paddr, pwdata}), 64'({32'h10, 32'hDEADBEEF}));
        tick();
        chk("wr_c3_valid_psel", 64'({rsp_valid, psel, penable}), 64'(3'b100));
        chk("wr_c3_rsp", 64'({rsp_write, rsp_rdata, rsp_timeout}), 64'({1'b1, 32'h0, 1'b0}));
        tick();
        chk("wr_c4_idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));

        // 3. read with two wait states
        slv_waits = 2;
        prdata    = 32'h12345678;
        do_cmd(1'b0, 32'h24, 32'h0);
        n = 1; acc = 0;
        while (!rsp_valid && n < 20) begin
            if (penable) acc++;
            tick();
            n++;
        end
        chk("rd_latency", 64'(n), 64'(5));
        chk("rd_access_cycles", 64'(acc), 64'(3));
        chk("rd_rsp", 64'({rsp_write, rsp_rdata, rsp_timeout}), 64'({1'b0, 32'h12345678, 1'b0}));
        tick();

        // 4. timeout
        slv_never = 1'b1;
        prdata    = 32'hA5A5A5A5;
        do_cmd(1'b0, 32'h30, 32'h0);
        n = 1; acc = 0;
        while (!rsp_valid && n < 30) begin
            if (penable) acc++;
            tick();
            n++;
        end
        chk("to_latency", 64'(n), 64'(TB_TIMEOUT + 2));
        chk("to_access_cycles", 64'(acc), 64'(TB_TIMEOUT));
        chk("to_rsp", 64'({rsp_write, rsp_rdata, rsp_timeout}), 64'({1'b0, 32'h0, 1'b1}));
        tick();

        // 5. back-pressure with a second command waiting
        slv_never = 1'b0;
        slv_waits = 0;
        prdata    = 32'h0BADF00D;
        rsp_ready = 1'b0;
        do_cmd(1'b1, 32'h40, 32'h000055AA);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h44;
        cmd_wdata = 32'h77;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_ctrl", 64'({rsp_valid, cmd_ready, psel}), 64'(3'b100));
            chk("bp_rsp", 64'({rsp_write, rsp_rdata, rsp_timeout}), 64'({1'b1, 32'h0, 1'b0}));
            chk("bp_paddr", 64'(paddr), 64'(32'h40));
            tick();
        end
        rsp_ready = 1'b1;
        chk("bp_release_ctrl", 64'({rsp_valid, cmd_ready}), 64'(2'b10));
        tick();
        chk("bp_idle", 64'({cmd_ready, psel, paddr}), 64'({1'b1, 1'b0, 32'h40}));
        tick();
        cmd_valid = 1'b0;
        chk("bp_second_setup", 64'({psel, penable, pwrite, paddr}), 64'({3'b100, 32'h44}));
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_second_rsp", 64'({rsp_write, rsp_rdata, rsp_timeout}), 64'({1'b0, 32'h0BADF00D, 1'b0}));
        tick();

        // 6. reset in the middle of ACCESS
        slv_waits = 3;
        do_cmd(1'b0, 32'h50, 32'h0);
        tick();
        chk("mid_access_pen", 64'({psel, penable}), 64'(2'b11));
        #1 preset = 1'b1;
        #1;
        chk("mid_reset_strobes", 64'({psel, penable, cmd_ready}), 64'(0));
        chk("mid_reset_bus", 64'({pwrite, paddr, pwdata}), 64'(0));
        tick();
        preset = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) hits++;
            tick();
        end
        chk("mid_reset_no_rsp", 64'(hits), 64'(0));
        slv_waits = 0;
        do_cmd(1'b1, 32'h60, 32'h0000CAFE);
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("post_reset_latency", 64'(n), 64'(3));
        chk("post_reset_rsp", 64'({rsp_write, rsp_timeout, pwdata}), 64'({2'b10, 32'h0000CAFE}));
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
